// File: rtl/conv2d_weight_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_params (package)
// Description : Shared constants, beat record and sequencer state encoding
//               for the conv2d weight/bias sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package conv2d_params;

    localparam int NUM_OUT_CHANNELS = 16;
    localparam int WEIGHTS_PER_CH_W = 216;
    localparam int BIAS_WIDTH       = 16;
    localparam int ADDR_W           = 8;
    localparam int PASS_W           = 16;

    // Channel index of the final channel in a sweep
    localparam logic [ADDR_W-1:0] C_LAST_CH = ADDR_W'(NUM_OUT_CHANNELS - 1);

    // One streamed beat: a channel's weights and bias plus position tags
    typedef struct packed {
        logic [WEIGHTS_PER_CH_W-1:0] weights;
        logic [BIAS_WIDTH-1:0]       bias;
        logic [ADDR_W-1:0]           ch;
        logic                        last_ch;
        logic                        last;
    } wt_beat_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/conv2d_weight_sequencer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_wt_skid_fifo
// Description : 2-entry FIFO of weight beats. Absorbs the ROM read latency
//               so the stream keeps 1 beat/cycle under backpressure. Push and
//               pop may coincide at any fill level.
// Revision    : 1.0 - initial release
// ============================================================================
module conv2d_wt_skid_fifo
    import conv2d_params::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_flush,
    input  logic       i_push,
    input  wt_beat_t   i_push_data,
    input  logic       i_pop,
    output wt_beat_t   o_head,
    output logic       o_valid,
    output logic [1:0] o_count
);

    wt_beat_t   mem_q [2];
    wt_beat_t   mem_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       w_pop_ok;

    assign w_pop_ok = i_pop && (count_q != 2'd0);
    assign o_valid  = (count_q != 2'd0);
    assign o_head   = mem_q[rd_ptr_q];
    assign o_count  = count_q;

    // Next-state for storage, pointers and fill level; flush wins over push
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (i_push) begin
                mem_d[wr_ptr_q] = i_push_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (w_pop_ok) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, i_push} - {1'b0, w_pop_ok};
        end
    end

    // FIFO state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // A push into a full FIFO without a matching pop would clobber the head
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(i_push && !i_flush && !w_pop_ok && (count_q == 2'd2)));

endmodule
`default_nettype wire

// File: rtl/conv2d_weight_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_weight_sequencer
// Description : Reads per-channel weights/bias from a 1-cycle ROM and streams
//               them over valid/ready, cfg_passes sweeps of all channels per
//               start. Reads are issued only when the 2-entry buffer plus the
//               in-flight read leave room, so the buffer can never overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module conv2d_weight_sequencer
    import conv2d_params::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [PASS_W-1:0]           cfg_passes,
    output logic                        busy,
    output logic                        done,
    output logic                        rom_en,
    output logic [ADDR_W-1:0]           rom_addr,
    input  logic [WEIGHTS_PER_CH_W-1:0] rom_weights,
    input  logic [BIAS_WIDTH-1:0]       rom_bias,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WEIGHTS_PER_CH_W-1:0] out_weights,
    output logic [BIAS_WIDTH-1:0]       out_bias,
    output logic [ADDR_W-1:0]           out_ch,
    output logic                        out_last_ch,
    output logic                        out_last
);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ch_q, ch_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic [PASS_W-1:0] passes_q, passes_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] tag_ch_q, tag_ch_d;
    logic              tag_last_ch_q, tag_last_ch_d;
    logic              tag_last_q, tag_last_d;

    logic              w_pop;
    logic              w_room;
    logic              w_last_ch;
    logic              w_last_pass;
    logic              w_fifo_valid;
    logic [1:0]        w_fifo_count;
    logic [2:0]        w_occupancy;
    wt_beat_t          w_push_beat;
    wt_beat_t          w_head;

    // Room exists when occupancy after this cycle's pop is below two
    assign w_pop       = w_fifo_valid && out_ready;
    assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, inflight_q};
    assign w_room      = w_occupancy < (3'd2 + {2'b00, w_pop});
    assign w_last_ch   = (ch_q == C_LAST_CH);
    assign w_last_pass = (pass_q == (passes_q - PASS_W'(1)));
    assign rom_addr    = ch_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides everything including start
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // A zero-pass start walks through an empty DRAIN so its
                    // done pulse lands two cycles after start
                    state_d = (cfg_passes != '0) ? S_RUN : S_DRAIN;
                end
            end
            S_RUN: begin
                if (rom_en && w_last_ch && w_last_pass) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!inflight_q && (w_fifo_count == 2'd0)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
        end
    end

    // State-decoded outputs; reads are issued only while running with room
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        rom_en = 1'b0;
        case (state_q)
            S_RUN: begin
                busy   = 1'b1;
                rom_en = w_room;
            end
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Channel/pass counters and tags travelling with each ROM read
    always_comb begin
        ch_d          = ch_q;
        pass_d        = pass_q;
        passes_d      = passes_q;
        tag_ch_d      = tag_ch_q;
        tag_last_ch_d = tag_last_ch_q;
        tag_last_d    = tag_last_q;
        inflight_d    = rom_en;
        if ((state_q == S_IDLE) && start) begin
            passes_d = cfg_passes;
            ch_d     = '0;
            pass_d   = '0;
        end
        if (rom_en) begin
            tag_ch_d      = ch_q;
            tag_last_ch_d = w_last_ch;
            tag_last_d    = w_last_ch && w_last_pass;
            if (w_last_ch) begin
                ch_d   = '0;
                pass_d = pass_q + PASS_W'(1);
            end else begin
                ch_d   = ch_q + ADDR_W'(1);
            end
        end
        if (abort) begin
            ch_d       = '0;
            pass_d     = '0;
            inflight_d = 1'b0;
        end
    end

    // Counter and read-pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q          <= '0;
            pass_q        <= '0;
            passes_q      <= '0;
            inflight_q    <= 1'b0;
            tag_ch_q      <= '0;
            tag_last_ch_q <= 1'b0;
            tag_last_q    <= 1'b0;
        end else begin
            ch_q          <= ch_d;
            pass_q        <= pass_d;
            passes_q      <= passes_d;
            inflight_q    <= inflight_d;
            tag_ch_q      <= tag_ch_d;
            tag_last_ch_q <= tag_last_ch_d;
            tag_last_q    <= tag_last_d;
        end
    end

    // ROM data arrives the cycle after rom_en and joins its registered tags
    always_comb begin
        w_push_beat.weights = rom_weights;
        w_push_beat.bias    = rom_bias;
        w_push_beat.ch      = tag_ch_q;
        w_push_beat.last_ch = tag_last_ch_q;
        w_push_beat.last    = tag_last_q;
    end

    conv2d_wt_skid_fifo u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (abort),
        .i_push      (inflight_q),
        .i_push_data (w_push_beat),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_valid     (w_fifo_valid),
        .o_count     (w_fifo_count)
    );

    assign out_valid   = w_fifo_valid;
    assign out_weights = w_head.weights;
    assign out_bias    = w_head.bias;
    assign out_ch      = w_head.ch;
    assign out_last_ch = w_head.last_ch;
    assign out_last    = w_head.last;

endmodule
`default_nettype wire

// File: tb/tb_conv2d_weight_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv2d_weight_sequencer
// Description : Self-checking bench for conv2d_weight_sequencer with a ROM
//               model, a table of runs, hand-written corner sequences and
//               randomised runs checked against an ideal beat-order model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv2d_weight_sequencer;
    import conv2d_params::*;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        start = 1'b0;
    logic                        abort = 1'b0;
    logic [PASS_W-1:0]           cfg_passes = '0;
    logic                        busy, done, rom_en;
    logic [ADDR_W-1:0]           rom_addr;
    logic [WEIGHTS_PER_CH_W-1:0] rom_weights = '0;
    logic [BIAS_WIDTH-1:0]       rom_bias = '0;
    logic                        out_valid;
    logic                        out_ready = 1'b0;
    logic [WEIGHTS_PER_CH_W-1:0] out_weights;
    logic [BIAS_WIDTH-1:0]       out_bias;
    logic [ADDR_W-1:0]           out_ch;
    logic                        out_last_ch, out_last;

    conv2d_weight_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_passes(cfg_passes), .busy(busy), .done(done),
        .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_weights(rom_weights), .rom_bias(rom_bias),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_weights(out_weights), .out_bias(out_bias), .out_ch(out_ch),
        .out_last_ch(out_last_ch), .out_last(out_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] salt = 32'd0;

    // ROM contents: weights = ch*3, bias = ch+100, perturbed by salt
    function automatic logic [WEIGHTS_PER_CH_W-1:0] wfun(input logic [ADDR_W-1:0] a);
        return (WEIGHTS_PER_CH_W'(a) * WEIGHTS_PER_CH_W'(3)) ^ (WEIGHTS_PER_CH_W'(salt) << 120);
    endfunction
    function automatic logic [BIAS_WIDTH-1:0] bfun(input logic [ADDR_W-1:0] a);
        return BIAS_WIDTH'(a) + 16'd100 + salt[31:16];
    endfunction

    // Registered-read ROM model
    always @(posedge clk) begin
        if (rom_en) begin
            rom_weights <= wfun(rom_addr);
            rom_bias    <= bfun(rom_addr);
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct { int rel; logic [ADDR_W-1:0] addr; } rd_rec_t;
    typedef struct { int rel; wt_beat_t b; } beat_rec_t;
    rd_rec_t   rd_log[$];
    beat_rec_t beat_log[$];
    int        done_log[$];
    int        t0 = 0;
    int        issued = 0;
    int        popped = 0;
    bit        prev_stall = 1'b0;
    wt_beat_t  prev_beat;

    // Observe the interface mid-cycle: log reads, beats, done; check holds
    always @(negedge clk) begin
        wt_beat_t  cur;
        rd_rec_t   rr;
        beat_rec_t br;
        cur.weights = out_weights;
        cur.bias    = out_bias;
        cur.ch      = out_ch;
        cur.last_ch = out_last_ch;
        cur.last    = out_last;
        if (!rst) begin
            if (prev_stall)
                check("stall_hold", {out_valid, cur}, {1'b1, prev_beat});
            if (rom_en) begin
                rr.rel = cyc - t0; rr.addr = rom_addr;
                rd_log.push_back(rr);
                issued++;
            end
            if (out_valid && out_ready) begin
                br.rel = cyc - t0; br.b = cur;
                beat_log.push_back(br);
                popped++;
            end
            if (rom_en)
                check("occupancy_le2", ((issued - popped) <= 2), 1);
            if (done) begin
                done_log.push_back(cyc - t0);
                check("busy_in_done", busy, 0);
            end
            prev_stall = out_valid && !out_ready && !abort;
            prev_beat  = cur;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Called right after a posedge; the following cycle is relative cycle 0
    task automatic begin_run(input int passes);
        rd_log.delete();
        beat_log.delete();
        done_log.delete();
        issued     = 0;
        popped     = 0;
        t0         = cyc;
        cfg_passes = PASS_W'(passes);
        start      = 1'b1;
    endtask

    task automatic wait_done(input int pct, input int budget);
        int extra = 0;
        for (int i = 0; i < budget && extra < 3; i++) begin
            out_ready = ($urandom_range(99) < pct);
            @(posedge clk); #1;
            if (done_log.size() != 0) extra++;
        end
        check("run_done_seen", (done_log.size() != 0), 1);
        out_ready = 1'b1;
    endtask

    task automatic run_seq(input int passes, input int pct);
        @(posedge clk); #1;
        out_ready = ($urandom_range(99) < pct);
        begin_run(passes);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(pct, 3000);
    endtask

    // Ideal stream: pass-major, channel-minor, one read per beat in order
    task automatic compare_stream(input int passes);
        int total = passes * NUM_OUT_CHANNELS;
        wt_beat_t e;
        check("beat_count", beat_log.size(), total);
        check("read_count", rd_log.size(), total);
        check("done_count", done_log.size(), 1);
        for (int i = 0; i < total && i < beat_log.size(); i++) begin
            int c = i % NUM_OUT_CHANNELS;
            int p = i / NUM_OUT_CHANNELS;
            e.weights = wfun(ADDR_W'(c));
            e.bias    = bfun(ADDR_W'(c));
            e.ch      = ADDR_W'(c);
            e.last_ch = (c == NUM_OUT_CHANNELS - 1);
            e.last    = (c == NUM_OUT_CHANNELS - 1) && (p == passes - 1);
            check($sformatf("beat%0d", i), beat_log[i].b, e);
        end
        for (int i = 0; i < total && i < rd_log.size(); i++)
            check($sformatf("read_addr%0d", i), rd_log[i].addr, i % NUM_OUT_CHANNELS);
    endtask

    typedef struct {
        int passes;
        int pct;
        int first_rd;
        int first_beat;
        int done_rel;
    } vec_t;
    vec_t tbl[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1, 100, 1, 3, 20};
        tbl[1] = '{3, 100, 1, 3, 52};
        tbl[2] = '{0, 100, -1, -1, 2};
        tbl[3] = '{2, 50, -1, -1, -1};
        tbl[4] = '{5, 100, 1, 3, 84};
        tbl[5] = '{4, 25, -1, -1, -1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rom_en", rom_en, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_payload", {out_weights, out_bias, out_ch, out_last_ch, out_last}, 0);
        rst = 1'b0;

        // Table-driven runs
        for (int t = 0; t < 6; t++) begin
            run_seq(tbl[t].passes, tbl[t].pct);
            compare_stream(tbl[t].passes);
            if (tbl[t].first_rd >= 0 && rd_log.size() > 0)
                check($sformatf("t%0d_first_read_cycle", t), rd_log[0].rel, tbl[t].first_rd);
            if (tbl[t].first_beat >= 0 && beat_log.size() > 0)
                check($sformatf("t%0d_first_beat_cycle", t), beat_log[0].rel, tbl[t].first_beat);
            if (tbl[t].done_rel >= 0 && done_log.size() > 0)
                check($sformatf("t%0d_done_cycle", t), done_log[0], tbl[t].done_rel);
        end

        // out_ready low from cycle 0: only two reads, then resume from addr 2
        @(posedge clk); #1;
        out_ready = 1'b0;
        begin_run(1);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        check("stall_read_count", rd_log.size(), 2);
        if (rd_log.size() >= 2) begin
            check("stall_addr0", rd_log[0].addr, 0);
            check("stall_addr1", rd_log[1].addr, 1);
        end
        check("stall_valid", out_valid, 1);
        check("stall_head_ch", out_ch, 0);
        wait_done(100, 200);
        compare_stream(1);

        // Abort at beat 5 of pass 0, then a clean single-pass run
        @(posedge clk); #1;
        out_ready = 1'b1;
        begin_run(2);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 60 && beat_log.size() < 5; i++) begin
            @(posedge clk); #1;
        end
        check("abort_reached_beat5", (beat_log.size() >= 5), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", out_valid, 0);
        check("abort_rom_en", rom_en, 0);
        repeat (30) begin @(posedge clk); #1; end
        check("abort_no_done", done_log.size(), 0);
        check("abort_idle_valid", out_valid, 0);
        run_seq(1, 100);
        compare_stream(1);

        // Reset in the middle of a run, then a clean run
        @(posedge clk); #1;
        out_ready = 1'b1;
        begin_run(2);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", busy, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_rom_en", rom_en, 0);
        check("midrst_rom_addr", rom_addr, 0);
        check("midrst_payload", {out_weights, out_bias, out_ch, out_last_ch, out_last}, 0);
        rst = 1'b0;
        run_seq(1, 60);
        compare_stream(1);

        // Start while busy is ignored
        @(posedge clk); #1;
        out_ready = 1'b1;
        begin_run(2);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        cfg_passes = PASS_W'(5);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(100, 500);
        compare_stream(2);

        // Randomised runs against the ideal stream model
        for (int r = 0; r < 6; r++) begin
            int p;
            int pct;
            salt = $urandom;
            p    = $urandom_range(3, 1);
            pct  = $urandom_range(95, 20);
            run_seq(p, pct);
            compare_stream(p);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
